kb_scan_ctrl: RTL and testbench
===============================

Name: kb_scan_ctrl

Overview:
- Sequences the PS/2 keyboard receiver: consumes 8-bit frames, decodes the make/break (F0) and extended (E0) prefix protocol into single key events, and buffers the events in a FIFO for the downstream driver.
- Owns receiver recovery. When a frame error occurs or a prefix sequence stalls, it returns to the idle state and pulses a clear back to the frame receiver.
- Sits between the PS/2 frame receiver and the keyboard driver/display logic.

Parameters:
- FIFO_DEPTH, 8, number of event entries; must be a power of 2 and at least 2.
- TIMEOUT_CYCLES, 50000, number of i_clk cycles a partial prefix sequence may wait for its next frame before it is abandoned; must be at least 2.

Ports:
- i_clk  in  1  system clock; all state updates on rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_frame_valid  in  1  one-cycle pulse: i_frame_data holds a complete, parity-checked frame.
- i_frame_data  in  8  received scan byte.
- i_frame_err  in  1  one-cycle pulse: receiver saw a parity, start or stop error.
- o_rx_clear  out  1  one-cycle pulse to reset the frame receiver's bit counter.
- o_key_valid  out  1  FIFO head holds an event.
- o_key_code  out  8  head event scan code.
- o_key_ext  out  1  head event was prefixed by E0.
- o_key_break  out  1  head event is a release (prefixed by F0).
- i_key_ready  in  1  consumer accepts the head event this cycle.
- o_overflow  out  1  sticky: an event was dropped because the FIFO was full.
- i_ovf_clr  in  1  clears o_overflow.
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  current number of stored events.

Behaviour:
Reset:
- Reset is asynchronous and active-high.
- FSM returns to IDLE; timeout counter cleared; FIFO pointers and count cleared.
- All outputs are 0 during and after reset: o_key_valid, o_key_code, o_key_ext, o_key_break, o_rx_clear, o_overflow, o_fifo_count.
- Reset mid-sequence discards any partial prefix and all buffered events.

FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Transitions act only on cycles where i_frame_valid=1 and i_frame_err=0.
- IDLE: E0 -> GOT_E0; F0 -> GOT_F0; any other byte -> push {ext=0, brk=0, code}, stay IDLE.
- GOT_E0: F0 -> GOT_E0F0; E0 -> stay GOT_E0; other byte -> push {1, 0, code}, go IDLE.
- GOT_F0: F0 -> stay GOT_F0; E0 -> GOT_E0F0; other byte -> push {0, 1, code}, go IDLE.
- GOT_E0F0: E0 or F0 -> stay; other byte -> push {1, 1, code}, go IDLE.
- All bytes other than E0 and F0 are key codes, including E1, AA and FA.

Frame errors:
- i_frame_err=1 forces the FSM to IDLE and pulses o_rx_clear on the next cycle; no push occurs.
- If i_frame_err and i_frame_valid are asserted in the same cycle, the error wins and the frame is discarded.

Prefix timeout:
- The counter runs only while the FSM is not in IDLE, and resets to 0 on every accepted frame.
- When the counter reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE, the counter resets, and o_rx_clear pulses for one cycle.

o_rx_clear is a registered output and is never high for more than one cycle per triggering event.

FIFO:
- First-word-fall-through. o_key_valid = (count != 0). o_key_* present the entry at the read pointer.
- Pop occurs when o_key_valid && i_key_ready. Pointers wrap modulo FIFO_DEPTH.
- Latency: a final frame accepted at edge N makes o_key_valid=1 in the cycle after N, provided the FIFO was empty.
- Push while full with no pop in the same cycle: the event is dropped, o_overflow is set, and count stays at FIFO_DEPTH.
- Push while full with a pop in the same cycle: the push is accepted and count is unchanged.
- Push and pop on an empty FIFO: the push is stored and count becomes 1 (no bypass).
- i_key_ready while the FIFO is empty is ignored.
- i_ovf_clr clears o_overflow. If i_ovf_clr and a new overflow occur in the same cycle, the overflow wins and o_overflow stays 1.

Test Plan:
- Make code: frame 1C -> one event {code=1C, ext=0, brk=0}; o_key_valid rises 1 cycle after the frame pulse; o_fifo_count=1; pop with i_key_ready -> count=0.
- Break and extended: frames F0,1C then E0,F0,75 -> events {1C,0,1} then {75,1,1}, in order.
- Overflow: 9 make codes with FIFO_DEPTH=8 and i_key_ready=0 -> count=8, o_overflow=1, ninth code absent; drain returns codes 1..8 in order; i_ovf_clr -> o_overflow=0.
- Timeout: TIMEOUT_CYCLES=20; frame E0, then idle for 20 cycles -> o_rx_clear pulses exactly once, FSM in IDLE; a following 1C -> event {1C,0,0}.
- Error: frame F0, then i_frame_valid=1 with i_frame_err=1 and data 1C -> no event, o_rx_clear pulse; next frame 1C -> event {1C,0,0}.
- Full push/pop: FIFO full with i_key_ready=1 and a new frame in the same cycle -> count stays 8, o_overflow stays 0, new code stored last.

Source files
------------

// File: rtl/kb_scan_ctrl.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixes into key events,
// buffers them in a FWFT FIFO and owns receiver recovery.
module kb_scan_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_frame_valid,
  input  logic [7:0]                    i_frame_data,
  input  logic                          i_frame_err,
  output logic                          o_rx_clear,
  output logic                          o_key_valid,
  output logic [7:0]                    o_key_code,
  output logic                          o_key_ext,
  output logic                          o_key_break,
  input  logic                          i_key_ready,
  output logic                          o_overflow,
  input  logic                          i_ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    GOT_E0,
    GOT_F0,
    GOT_E0F0
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_tmo;
  logic          r_rx_clear;

  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic w_acc;
  logic w_is_e0;
  logic w_is_f0;
  logic w_push;
  logic w_ext;
  logic w_brk;
  logic w_full;
  logic w_pop;
  logic w_wr;
  logic w_drop;

  assign w_acc   = i_frame_valid && !i_frame_err;
  assign w_is_e0 = (i_frame_data == 8'hE0);
  assign w_is_f0 = (i_frame_data == 8'hF0);
  assign w_push  = w_acc && !w_is_e0 && !w_is_f0;
  assign w_ext   = (r_state == GOT_E0) || (r_state == GOT_E0F0);
  assign w_brk   = (r_state == GOT_F0) || (r_state == GOT_E0F0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_tmo      <= '0;
      r_rx_clear <= 1'b0;
    end else begin
      r_rx_clear <= 1'b0;
      if (i_frame_err) begin
        r_state    <= IDLE;
        r_tmo      <= '0;
        r_rx_clear <= 1'b1;
      end else if (i_frame_valid) begin
        r_tmo <= '0;
        unique case (1'b1)
          w_is_e0: r_state <= (r_state == IDLE || r_state == GOT_E0)
                              ? GOT_E0 : GOT_E0F0;
          w_is_f0: r_state <= (r_state == GOT_E0 || r_state == GOT_E0F0)
                              ? GOT_E0F0 : GOT_F0;
          default: r_state <= IDLE;
        endcase
      end else if (r_state != IDLE) begin
        // a stalled prefix is abandoned and the receiver resynced
        if (r_tmo == TMO_MAX) begin
          r_state    <= IDLE;
          r_tmo      <= '0;
          r_rx_clear <= 1'b1;
        end else begin
          r_tmo <= r_tmo + TW'(1);
        end
      end
    end
  end

  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = (r_count != '0) && i_key_ready;
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= {w_ext, w_brk, i_frame_data};
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_wr) - CW'(w_pop);
      if (w_drop)         r_ovf <= 1'b1;
      else if (i_ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign o_rx_clear   = r_rx_clear;
  assign o_key_valid  = (r_count != '0);
  assign o_key_ext    = r_mem[r_rptr][9];
  assign o_key_break  = r_mem[r_rptr][8];
  assign o_key_code   = r_mem[r_rptr][7:0];
  assign o_overflow   = r_ovf;
  assign o_fifo_count = r_count;

endmodule

// File: tb/tb_kb_scan_ctrl.sv
// Directed bench for kb_scan_ctrl: vector table for single-frame
// behaviour plus sequences for timeout, overflow and reset.
module tb_kb_scan_ctrl;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_frame_valid;
  logic [7:0] i_frame_data;
  logic       i_frame_err;
  logic       o_rx_clear;
  logic       o_key_valid;
  logic [7:0] o_key_code;
  logic       o_key_ext;
  logic       o_key_break;
  logic       i_key_ready;
  logic       o_overflow;
  logic       i_ovf_clr;
  logic [3:0] o_fifo_count;

  int n_chk = 0;
  int n_err = 0;

  kb_scan_ctrl #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(20)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_frame_valid(i_frame_valid),
    .i_frame_data (i_frame_data),
    .i_frame_err  (i_frame_err),
    .o_rx_clear   (o_rx_clear),
    .o_key_valid  (o_key_valid),
    .o_key_code   (o_key_code),
    .o_key_ext    (o_key_ext),
    .o_key_break  (o_key_break),
    .i_key_ready  (i_key_ready),
    .o_overflow   (o_overflow),
    .i_ovf_clr    (i_ovf_clr),
    .o_fifo_count (o_fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fv;
    logic       fe;
    logic [7:0] d;
    logic       rdy;
    logic       ev;
    logic [7:0] ec;
    logic       ex;
    logic       eb;
    logic       clr;
    logic [3:0] cnt;
  } vec_t;

  vec_t tv [29];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_frame_valid = 1'b1;
    i_frame_data  = b;
    tick();
    i_frame_valid = 1'b0;
    i_frame_data  = 8'h00;
  endtask

  task automatic pop;
    i_key_ready = 1'b1;
    tick();
    i_key_ready = 1'b0;
  endtask

  task automatic chk_head(input string nm, input logic [7:0] c,
                          input logic x, input logic b);
    chk({nm, " valid"}, o_key_valid, 1);
    chk({nm, " code"}, o_key_code, c);
    chk({nm, " ext"}, o_key_ext, x);
    chk({nm, " brk"}, o_key_break, b);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " valid"}, o_key_valid, 0);
    chk({nm, " code"}, o_key_code, 0);
    chk({nm, " ext"}, o_key_ext, 0);
    chk({nm, " brk"}, o_key_break, 0);
    chk({nm, " clr"}, o_rx_clear, 0);
    chk({nm, " ovf"}, o_overflow, 0);
    chk({nm, " cnt"}, o_fifo_count, 0);
  endtask

  initial begin
    int npulse;
    int at;
    logic [7:0] ec;

    tv[0]  = '{1, 0, 8'h1C, 0, 1, 8'h1C, 0, 0, 0, 1};
    tv[1]  = '{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0};
    tv[2]  = '{1, 0, 8'hF0, 0, 0, 8'h00, 0, 0, 0, 0};
    tv[3]  = '{1, 0, 8'h1C, 0, 1, 8'h1C, 0, 1, 0, 1};
    tv[4]  = '{1, 0, 8'hE0, 0, 1, 8'h1C, 0, 1, 0, 1};
    tv[5]  = '{1, 0, 8'hF0, 0, 1, 8'h1C, 0, 1, 0, 1};
    tv[6]  = '{1, 0, 8'h75, 0, 1, 8'h1C, 0, 1, 0, 2};
    tv[7]  = '{0, 0, 8'h00, 1, 1, 8'h75, 1, 1, 0, 1};
    tv[8]  = '{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0};
    tv[9]  = '{1, 0, 8'hE0, 0, 0, 8'h00, 0, 0, 0, 0};
    tv[10] = '{1, 0, 8'hE0, 0, 0, 8'h00, 0, 0, 0, 0};
    tv[11] = '{1, 0, 8'h6B, 0, 1, 8'h6B, 1, 0, 0, 1};
    tv[12] = '{1, 0, 8'hF0, 0, 1, 8'h6B, 1, 0, 0, 1};
    tv[13] = '{1, 0, 8'hF0, 0, 1, 8'h6B, 1, 0, 0, 1};
    tv[14] = '{1, 0, 8'hE0, 0, 1, 8'h6B, 1, 0, 0, 1};
    tv[15] = '{1, 0, 8'hE0, 0, 1, 8'h6B, 1, 0, 0, 1};
    tv[16] = '{1, 0, 8'h71, 1, 1, 8'h71, 1, 1, 0, 1};
    tv[17] = '{1, 0, 8'hE1, 1, 1, 8'hE1, 0, 0, 0, 1};
    tv[18] = '{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0};
    tv[19] = '{1, 0, 8'hF0, 0, 0, 8'h00, 0, 0, 0, 0};
    tv[20] = '{1, 1, 8'h1C, 0, 0, 8'h00, 0, 0, 1, 0};
    tv[21] = '{1, 0, 8'h1C, 0, 1, 8'h1C, 0, 0, 0, 1};
    tv[22] = '{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0};
    tv[23] = '{1, 0, 8'hAA, 1, 1, 8'hAA, 0, 0, 0, 1};
    tv[24] = '{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0};
    tv[25] = '{0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0};
    tv[26] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0};
    tv[27] = '{1, 0, 8'hFA, 0, 1, 8'hFA, 0, 0, 0, 1};
    tv[28] = '{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0};

    i_rst = 1'b1;
    i_frame_valid = 1'b0;
    i_frame_data = 8'h00;
    i_frame_err = 1'b0;
    i_key_ready = 1'b0;
    i_ovf_clr = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    i_rst = 1'b0;
    tick();
    chk_zero("post-reset");

    for (int i = 0; i < 29; i++) begin
      i_frame_valid = tv[i].fv;
      i_frame_err   = tv[i].fe;
      i_frame_data  = tv[i].d;
      i_key_ready   = tv[i].rdy;
      tick();
      i_frame_valid = 1'b0;
      i_frame_err   = 1'b0;
      i_frame_data  = 8'h00;
      i_key_ready   = 1'b0;
      chk($sformatf("v%0d clr", i), o_rx_clear, tv[i].clr);
      chk($sformatf("v%0d cnt", i), o_fifo_count, tv[i].cnt);
      chk($sformatf("v%0d valid", i), o_key_valid, tv[i].ev);
      if (tv[i].ev) begin
        chk($sformatf("v%0d code", i), o_key_code, tv[i].ec);
        chk($sformatf("v%0d ext", i), o_key_ext, tv[i].ex);
        chk($sformatf("v%0d brk", i), o_key_break, tv[i].eb);
      end
    end

    send(8'hE0);
    npulse = 0;
    at = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (o_rx_clear) begin
        npulse++;
        at = i;
      end
    end
    chk("tmo pulses", npulse, 1);
    chk("tmo cycle", at, 20);
    send(8'h1C);
    chk_head("tmo next", 8'h1C, 0, 0);
    pop();

    npulse = 0;
    send(8'hE0);
    for (int i = 0; i < 15; i++) begin
      tick();
      if (o_rx_clear) npulse++;
    end
    send(8'hF0);
    for (int i = 0; i < 15; i++) begin
      tick();
      if (o_rx_clear) npulse++;
    end
    chk("tmo restart pulses", npulse, 0);
    send(8'h7C);
    chk_head("tmo restart", 8'h7C, 1, 1);
    pop();
    chk("tmo restart cnt", o_fifo_count, 0);

    for (int k = 1; k <= 9; k++) begin
      send(8'(k));
      if (k == 8) begin
        chk("ovf cnt8", o_fifo_count, 8);
        chk("ovf pre", o_overflow, 0);
      end
    end
    chk("ovf cnt9", o_fifo_count, 8);
    chk("ovf set", o_overflow, 1);
    chk("ovf head", o_key_code, 8'h01);
    i_ovf_clr = 1'b1;
    tick();
    i_ovf_clr = 1'b0;
    chk("ovf clr", o_overflow, 0);

    i_key_ready = 1'b1;
    send(8'h0B);
    i_key_ready = 1'b0;
    chk("fullpp cnt", o_fifo_count, 8);
    chk("fullpp ovf", o_overflow, 0);
    for (int i = 0; i < 8; i++) begin
      ec = (i < 7) ? 8'(i + 2) : 8'h0B;
      chk($sformatf("drain%0d valid", i), o_key_valid, 1);
      chk($sformatf("drain%0d code", i), o_key_code, ec);
      pop();
    end
    chk("drain cnt", o_fifo_count, 0);
    chk("drain valid", o_key_valid, 0);

    for (int k = 0; k < 8; k++) send(8'(8'h11 + k));
    i_ovf_clr = 1'b1;
    send(8'h19);
    i_ovf_clr = 1'b0;
    chk("ovf vs clr", o_overflow, 1);
    chk("ovf vs clr cnt", o_fifo_count, 8);

    send(8'hE0);
    i_rst = 1'b1;
    #1;
    chk_zero("async reset");
    tick();
    i_rst = 1'b0;
    tick();
    send(8'h1C);
    chk_head("after reset", 8'h1C, 0, 0);
    chk("after reset cnt", o_fifo_count, 1);
    chk("after reset ovf", o_overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
